spike_encoder: RTL and testbench

SPIKE_ENCODER -- requirements
Module: spike_encoder

---
 rtl/snn_pkg.sv | 27 ++
 rtl/lfsr16.sv | 40 ++++
 rtl/spike_encoder.sv | 117 +++++++++++
 tb/tb_spike_encoder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-network front end: LFSR geometry, the
// Fibonacci tap mask, the default seed, the encoder FSM state type and a
// rotate helper used to derive per-lane random values from one LFSR.
// ---------------------------------------------------------------------------
package snn_pkg;

  localparam int          LFSR_W       = 16;
  // Taps 16,14,13,11 (1-based) -> bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Rotate left by k (mod LFSR_W), taken as a window of the doubled word.
  function automatic logic [LFSR_W-1:0] rotl(input logic [LFSR_W-1:0] v,
                                             input int unsigned       k);
    logic [2*LFSR_W-1:0] d;
    d = {v, v};
    return d[(2*LFSR_W-1) - int'(k % LFSR_W) -: LFSR_W];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR, shift-left with feedback into bit 0.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, state returns to RESET_SEED
//   load_i  : load seed_i (takes priority over en_i)
//   seed_i  : value loaded on load_i
//   en_i    : advance one step
//   state_o : current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
  import snn_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RESET_SEED;
    end else if (load_i) begin
      state_q <= seed_i;
    end else if (en_i) begin
      state_q <= {state_q[14:0], ^(state_q & LFSR_TAPS)};
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/spike_encoder.sv
// ---------------------------------------------------------------------------
// spike_encoder
// Rate-codes a sample of NUM_INPUTS pixel intensities into NUM_STEPS
// timesteps of Bernoulli spikes: lane i spikes when its rotated LFSR value
// is below the pixel intensity (all-ones pixels always spike).
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   valid_i       : sample present on pixels_i (accepted while ready_o=1)
//   ready_o       : encoder idle and able to accept a sample
//   pixels_i      : packed intensities, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   spikes_o      : per-lane spikes for the current timestep
//   spike_valid_o : spikes_o/step_o hold a valid timestep
//   step_o        : timestep index 0..NUM_STEPS-1
//   done_o        : one-cycle pulse after the final timestep of a window
// Timing: handshake edge loads pixels and reseeds the LFSR; each following
// RUN cycle compares, and results are registered, so step 0 is visible two
// cycles after the handshake cycle. One drain cycle in RUN follows the last
// compare, then done_o pulses together with the return to IDLE.
// ---------------------------------------------------------------------------
module spike_encoder
  import snn_pkg::*;
#(
  parameter int          NUM_INPUTS = 1,
  parameter int          DATA_WIDTH = 8,
  parameter int          NUM_STEPS  = 100,
  parameter logic [15:0] SEED       = DEFAULT_SEED
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] pixels_i,
  output logic [NUM_INPUTS-1:0]            spikes_o,
  output logic                             spike_valid_o,
  output logic [$clog2(NUM_STEPS+1)-1:0]   step_o,
  output logic                             done_o
);

  localparam int                STEP_W   = $clog2(NUM_STEPS + 1);
  // Counter value reached after the last compare: marks the drain cycle.
  localparam logic [STEP_W-1:0] LAST_CNT = STEP_W'(NUM_STEPS);

  state_e                           state_q;
  logic [STEP_W-1:0]                cnt_q;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] pix_q;
  logic [15:0]                      lfsr;
  logic [NUM_INPUTS-1:0]            spike_d;
  logic                             handshake;
  logic                             compare_en;

  assign ready_o    = (state_q == ST_IDLE);
  assign handshake  = ready_o && valid_i;
  assign compare_en = (state_q == ST_RUN) && (cnt_q != LAST_CNT);

  // Advance happens on the compare edge, so each compare sees the state
  // that was current during its own cycle.
  lfsr16 #(
    .RESET_SEED(SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (handshake),
    .seed_i (SEED),
    .en_i   (compare_en),
    .state_o(lfsr)
  );

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    localparam int unsigned ROT = i % 16;
    logic [DATA_WIDTH-1:0] rnd;
    logic [DATA_WIDTH-1:0] pix;
    assign rnd        = DATA_WIDTH'(rotl(lfsr, ROT));
    assign pix        = pix_q[i*DATA_WIDTH +: DATA_WIDTH];
    // A full-scale pixel must spike every step; r < pixel alone cannot.
    assign spike_d[i] = (&pix) | (rnd < pix);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pix_q         <= '0;
      spikes_o      <= '0;
      spike_valid_o <= 1'b0;
      step_o        <= '0;
      done_o        <= 1'b0;
    end else begin
      // NOTE: outputs default to their quiet values each edge; only the
      // compare branch overrides them, which also makes done_o a pulse.
      spikes_o      <= '0;
      spike_valid_o <= 1'b0;
      step_o        <= '0;
      done_o        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            pix_q   <= pixels_i;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt_q != LAST_CNT) begin
            spikes_o      <= spike_d;
            spike_valid_o <= 1'b1;
            step_o        <= cnt_q;
            cnt_q         <= cnt_q + 1'b1;
          end else begin
            state_q <= ST_IDLE;
            done_o  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// ---------------------------------------------------------------------------
// tb_spike_encoder
// Directed bench: a 4-lane, 100-step encoder and a 1-lane, 1-step encoder.
// Each window is recorded cycle by cycle (cycle 1 = first cycle after the
// handshake edge) and compared against an independent LFSR/rotation model.
// ---------------------------------------------------------------------------
module tb_spike_encoder;

  localparam int          NI   = 4;
  localparam int          DW   = 8;
  localparam int          NS   = 100;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          valid;
  logic [31:0]   pixels;
  logic          ready;
  logic [3:0]    spikes;
  logic          sv;
  logic [6:0]    step;
  logic          done;

  logic          valid1;
  logic [7:0]    pix1;
  logic          ready1;
  logic [0:0]    spikes1;
  logic          sv1;
  logic [0:0]    step1;
  logic          done1;

  spike_encoder #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .NUM_STEPS(NS), .SEED(SEED)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .pixels_i(pixels),
    .spikes_o(spikes), .spike_valid_o(sv), .step_o(step), .done_o(done)
  );

  spike_encoder #(.NUM_INPUTS(1), .DATA_WIDTH(8), .NUM_STEPS(1), .SEED(SEED)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid1), .ready_o(ready1), .pixels_i(pix1),
    .spikes_o(spikes1), .spike_valid_o(sv1), .step_o(step1), .done_o(done1)
  );

  int total  = 0;
  int passed = 0;

  logic       rec_ready [0:NS+2];
  logic       rec_sv    [0:NS+2];
  logic       rec_done  [0:NS+2];
  logic [3:0] rec_spk   [0:NS+2];
  logic [6:0] rec_step  [0:NS+2];

  function automatic logic [15:0] m_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [3:0] m_spikes(input logic [15:0] s, input logic [31:0] pix);
    logic [3:0]  res;
    logic [15:0] r;
    logic [7:0]  p;
    for (int lane = 0; lane < NI; lane++) begin
      r = s;
      for (int j = 0; j < lane; j++) r = {r[14:0], r[15]};
      p = pix[lane*8 +: 8];
      res[lane] = (p == 8'hFF) || (r[7:0] < p);
    end
    return res;
  endfunction

  // Runs from the handshake edge through the done cycle (cycle NS+2),
  // optionally holding valid_i high with junk pixels during RUN and
  // optionally offering the next sample in the done cycle.
  task automatic do_window(input bit noise, input bit chain, input logic [31:0] next_pix);
    @(posedge clk);
    for (int c = 1; c <= NS + 2; c++) begin
      @(negedge clk);
      rec_ready[c] = ready;
      rec_sv[c]    = sv;
      rec_done[c]  = done;
      rec_spk[c]   = spikes;
      rec_step[c]  = step;
      if (noise) begin
        valid  = 1'b1;
        pixels = $urandom;
      end else begin
        valid = 1'b0;
      end
      if (c == NS + 2) begin
        valid = chain;
        if (chain) pixels = next_pix;
      end
    end
  endtask

  task automatic verify_window(input logic [31:0] pix, input string tag);
    logic [15:0] m;
    logic        exp_sv;
    logic [3:0]  exp_spk;
    m = SEED;
    for (int c = 1; c <= NS + 2; c++) begin
      exp_sv = (c >= 2) && (c <= NS + 1);
      total++;
      if (rec_ready[c] !== (c == NS + 2))
        $display("FAIL %s ready c=%0d: got %b expected %b", tag, c, rec_ready[c], (c == NS + 2));
      else passed++;
      total++;
      if (rec_sv[c] !== exp_sv)
        $display("FAIL %s spike_valid c=%0d: got %b expected %b", tag, c, rec_sv[c], exp_sv);
      else passed++;
      total++;
      if (rec_done[c] !== (c == NS + 2))
        $display("FAIL %s done c=%0d: got %b expected %b", tag, c, rec_done[c], (c == NS + 2));
      else passed++;
      exp_spk = 4'h0;
      if (exp_sv) begin
        exp_spk = m_spikes(m, pix);
        m = m_next(m);
        total++;
        if (rec_step[c] !== 7'(c - 2))
          $display("FAIL %s step c=%0d: got %0d expected %0d", tag, c, rec_step[c], c - 2);
        else passed++;
      end
      total++;
      if (rec_spk[c] !== exp_spk)
        $display("FAIL %s spikes c=%0d: got %h expected %h", tag, c, rec_spk[c], exp_spk);
      else passed++;
    end
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    valid  = 1'b0;
    pixels = '0;
    valid1 = 1'b0;
    pix1   = '0;
    #3;
    total++; if (ready !== 1'b1) $display("FAIL reset ready: got %b expected 1", ready); else passed++;
    total++; if (sv !== 1'b0) $display("FAIL reset spike_valid: got %b expected 0", sv); else passed++;
    total++; if (spikes !== 4'h0) $display("FAIL reset spikes: got %h expected 0", spikes); else passed++;
    total++; if (step !== 7'd0) $display("FAIL reset step: got %0d expected 0", step); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset done: got %b expected 0", done); else passed++;
    total++; if (ready1 !== 1'b1) $display("FAIL reset ready1: got %b expected 1", ready1); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_main;
    logic [31:0] p;
    int          cnt [NI];
    int          dcnt;
    p = 32'h0180_FF00;  // lanes {0:0x00, 1:0xFF, 2:0x80, 3:0x01}
    @(negedge clk);
    valid  = 1'b1;
    pixels = p;
    do_window(1'b0, 1'b0, '0);
    verify_window(p, "main");
    for (int l = 0; l < NI; l++) cnt[l] = 0;
    dcnt = 0;
    for (int c = 1; c <= NS + 2; c++) begin
      if (rec_sv[c]) for (int l = 0; l < NI; l++) cnt[l] += int'(rec_spk[c][l]);
      dcnt += int'(rec_done[c]);
    end
    total++; if (cnt[0] != 0) $display("FAIL lane0 count: got %0d expected 0", cnt[0]); else passed++;
    total++; if (cnt[1] != 100) $display("FAIL lane1 count: got %0d expected 100", cnt[1]); else passed++;
    total++; if (cnt[2] < 40 || cnt[2] > 60) $display("FAIL lane2 count: got %0d expected 40..60", cnt[2]); else passed++;
    total++; if (cnt[3] > 3) $display("FAIL lane3 count: got %0d expected 0..3", cnt[3]); else passed++;
    total++; if (dcnt != 1) $display("FAIL done pulses: got %0d expected 1", dcnt); else passed++;
    total++; if (rec_done[102] !== 1'b1) $display("FAIL done at 102: got %b expected 1", rec_done[102]); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL done after pulse: got %b expected 0", done); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL ready after window: got %b expected 1", ready); else passed++;
  endtask

  task automatic test_pattern;
    logic [31:0] p;
    p = 32'hFE03_C840;
    valid  = 1'b1;
    pixels = p;
    do_window(1'b0, 1'b0, '0);
    verify_window(p, "pattern");
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] p;
    logic [3:0]  first [0:NS+2];
    int          diffs;
    int          low;
    p = 32'h7F10_A0C3;
    valid  = 1'b1;
    pixels = p;
    do_window(1'b0, 1'b1, p);
    verify_window(p, "b2b_first");
    for (int c = 1; c <= NS + 2; c++) first[c] = rec_spk[c];
    low = 0;
    for (int c = 1; c <= NS + 2; c++) low += int'(rec_ready[c] == 1'b0);
    total++; if (low != NS + 1) $display("FAIL b2b ready-low first: got %0d expected %0d", low, NS + 1); else passed++;
    do_window(1'b0, 1'b0, '0);
    verify_window(p, "b2b_second");
    diffs = 0;
    low   = 0;
    for (int c = 1; c <= NS + 2; c++) begin
      diffs += int'(first[c] !== rec_spk[c]);
      low   += int'(rec_ready[c] == 1'b0);
    end
    total++; if (diffs != 0) $display("FAIL b2b identical trains: got %0d differing steps expected 0", diffs); else passed++;
    total++; if (low != NS + 1) $display("FAIL b2b ready-low second: got %0d expected %0d", low, NS + 1); else passed++;
    @(negedge clk);
  endtask

  task automatic test_valid_during_run;
    logic [31:0] a;
    logic [31:0] b;
    a = 32'h2040_6080;
    b = 32'hFFFF_0011;
    valid  = 1'b1;
    pixels = a;
    do_window(1'b1, 1'b1, b);
    verify_window(a, "busy_first");
    do_window(1'b0, 1'b0, '0);
    verify_window(b, "busy_next");
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] r;
    r = 32'h55AA_33CC;
    valid  = 1'b1;
    pixels = r;
    @(posedge clk);
    for (int c = 1; c <= 39; c++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    total++; if (step !== 7'd37) $display("FAIL mid-run step: got %0d expected 37", step); else passed++;
    total++; if (sv !== 1'b1) $display("FAIL mid-run spike_valid: got %b expected 1", sv); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (ready !== 1'b1) $display("FAIL async ready: got %b expected 1", ready); else passed++;
    total++; if (sv !== 1'b0) $display("FAIL async spike_valid: got %b expected 0", sv); else passed++;
    total++; if (spikes !== 4'h0) $display("FAIL async spikes: got %h expected 0", spikes); else passed++;
    total++; if (step !== 7'd0) $display("FAIL async step: got %0d expected 0", step); else passed++;
    total++; if (done !== 1'b0) $display("FAIL async done: got %b expected 0", done); else passed++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || sv !== 1'b0 || ready !== 1'b1)
        $display("FAIL post-reset idle c=%0d: got done=%b sv=%b ready=%b expected 0 0 1", c, done, sv, ready);
      else passed++;
    end
    valid  = 1'b1;
    pixels = r;
    do_window(1'b0, 1'b0, '0);
    verify_window(r, "after_reset");
    @(negedge clk);
  endtask

  task automatic test_single_step;
    logic       e_ready [1:4];
    logic       e_sv    [1:4];
    logic       e_done  [1:4];
    e_ready = '{1'b0, 1'b0, 1'b1, 1'b1};
    e_sv    = '{1'b0, 1'b1, 1'b0, 1'b0};
    e_done  = '{1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    valid1 = 1'b1;
    pix1   = 8'hFF;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      valid1 = 1'b0;
      total++;
      if (ready1 !== e_ready[c]) $display("FAIL single ready c=%0d: got %b expected %b", c, ready1, e_ready[c]); else passed++;
      total++;
      if (sv1 !== e_sv[c]) $display("FAIL single spike_valid c=%0d: got %b expected %b", c, sv1, e_sv[c]); else passed++;
      total++;
      if (done1 !== e_done[c]) $display("FAIL single done c=%0d: got %b expected %b", c, done1, e_done[c]); else passed++;
      total++;
      if (spikes1 !== e_sv[c]) $display("FAIL single spike c=%0d: got %b expected %b", c, spikes1, e_sv[c]); else passed++;
      if (c == 2) begin
        total++;
        if (step1 !== 1'b0) $display("FAIL single step: got %0d expected 0", step1); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_pattern();
    test_back_to_back();
    test_valid_during_run();
    test_reset_mid_run();
    test_single_step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
